// File: rtl/store_write_buffer.sv
// Posted-write store buffer: core stores retire into a circular FIFO that drains to memory
// in program order, while loads snoop pending entries for youngest-store forwarding.
module store_write_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWrite,
    input  logic [AW-1:0] DataAdr,
    input  logic [DW-1:0] WriteData,
    output logic          StallStore,
    input  logic          LoadReq,
    input  logic [AW-1:0] LoadAdr,
    output logic          LoadHit,
    output logic [DW-1:0] LoadData,
    output logic          mem_valid,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    output logic          Empty,
    output logic [CW-1:0] Count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [AW-1:0] adr_q  [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          full;
    logic          enq;
    logic          deq;

    assign full       = (count_q == CW'(DEPTH));
    assign mem_valid  = (count_q != '0);
    assign mem_adr    = adr_q[head_q];
    assign mem_wdata  = data_q[head_q];
    assign Empty      = ~mem_valid;
    assign Count      = count_q;

    // A same-cycle drain frees a slot, so a full buffer still accepts the store.
    assign StallStore = MemWrite & full & ~mem_ready;
    assign enq        = MemWrite & ~StallStore;
    assign deq        = mem_valid & mem_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CW'(enq) - CW'(deq);
        if (deq) begin
            head_d = head_q + PW'(1);
        end
        if (enq) begin
            tail_d = tail_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload carries no reset; occupancy is tracked solely by count_q.
    always_ff @(posedge clk) begin
        if (enq) begin
            adr_q[tail_q]  <= DataAdr;
            data_q[tail_q] <= WriteData;
        end
    end

    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic [PW-1:0] fwd_idx;

    // Walk oldest to youngest so the last match found is the youngest pending store.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (adr_q[fwd_idx][AW-1:2] == LoadAdr[AW-1:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end

    assign LoadHit  = LoadReq & fwd_hit;
    assign LoadData = LoadHit ? fwd_data : '0;

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed table, corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_store_write_buffer;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        StallStore;
    logic        LoadReq;
    logic [31:0] LoadAdr;
    logic        LoadHit;
    logic [31:0] LoadData;
    logic        mem_valid;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        Empty;
    logic [2:0]  Count;

    store_write_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .DataAdr    (DataAdr),
        .WriteData  (WriteData),
        .StallStore (StallStore),
        .LoadReq    (LoadReq),
        .LoadAdr    (LoadAdr),
        .LoadHit    (LoadHit),
        .LoadData   (LoadData),
        .mem_valid  (mem_valid),
        .mem_adr    (mem_adr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .Empty      (Empty),
        .Count      (Count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        mw;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        lr;
        logic [31:0] ladr;
        logic        rdy;
        logic        e_stall;
        logic        e_hit;
        logic [31:0] e_ld;
        logic        e_valid;
        logic [31:0] e_madr;
        int          e_cnt;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    ent_t q[$];
    ent_t drained[$];
    ent_t m_ent;
    logic m_enq, m_deq, m_stall;
    logic record = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic mw, input logic [31:0] adr, input logic [31:0] wd,
                         input logic lr, input logic [31:0] la, input logic rdy);
        MemWrite  = mw;
        DataAdr   = adr;
        WriteData = wd;
        LoadReq   = lr;
        LoadAdr   = la;
        mem_ready = rdy;
    endtask

    // Reference: pending stores are a plain queue; head is q[0], youngest is the back.
    task automatic settle();
        int          n;
        logic        ev, estall, ehit;
        logic [31:0] eld;
        @(negedge clk);
        n      = q.size();
        ev     = (n != 0);
        estall = MemWrite && (n == DEPTH) && !mem_ready;
        ehit   = 1'b0;
        eld    = '0;
        if (LoadReq) begin
            foreach (q[k]) begin
                if (q[k].adr[31:2] == LoadAdr[31:2]) begin
                    ehit = 1'b1;
                    eld  = q[k].data;
                end
            end
        end
        chk("m_count", 64'(Count), 64'(n));
        chk("m_empty", 64'(Empty), 64'(n == 0));
        chk("m_valid", 64'(mem_valid), 64'(ev));
        chk("m_stall", 64'(StallStore), 64'(estall));
        chk("m_hit", 64'(LoadHit), 64'(ehit));
        chk("m_ldata", 64'(LoadData), 64'(eld));
        if (ev) begin
            chk("m_adr", 64'(mem_adr), 64'(q[0].adr));
            chk("m_wdata", 64'(mem_wdata), 64'(q[0].data));
        end
        m_deq   = reset && ev && mem_ready;
        m_enq   = reset && MemWrite && !estall;
        m_stall = estall;
        m_ent   = '{DataAdr, WriteData};
        if (record && mem_valid && mem_ready) drained.push_back('{mem_adr, mem_wdata});
    endtask

    task automatic advance();
        @(posedge clk);
        if (!reset) begin
            q.delete();
        end else begin
            if (m_deq) void'(q.pop_front());
            if (m_enq) q.push_back(m_ent);
        end
        #1;
    endtask

    function automatic vec_t mk(input logic mw, input int adr, input int wd, input logic lr,
                                input int la, input logic rdy, input logic st, input logic h,
                                input int ld, input logic v, input int ma, input int c);
        vec_t t;
        t = '{mw, 32'(adr), 32'(wd), lr, 32'(la), rdy, st, h, 32'(ld), v, 32'(ma), c};
        return t;
    endfunction

    initial begin
        vec_t vecs[$];
        int   i, cyc;

        // Reset then idle
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_empty", 64'(Empty), 64'd1);
        chk("rst_count", 64'(Count), 64'd0);
        chk("rst_valid", 64'(mem_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        LoadReq = 1'b1;
        LoadAdr = 32'd96;
        repeat (2) begin
            settle();
            advance();
        end
        chk("idle_stall", 64'(StallStore), 64'd0);
        chk("idle_hit", 64'(LoadHit), 64'd0);

        // Single store, held stable while memory is not ready, then drained
        drive(1, 100, 7, 0, 0, 0);
        settle();
        advance();
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) begin
            settle();
            chk("hold_valid", 64'(mem_valid), 64'd1);
            chk("hold_adr", 64'(mem_adr), 64'd100);
            chk("hold_wdata", 64'(mem_wdata), 64'd7);
            advance();
        end
        mem_ready = 1'b1;
        settle();
        advance();
        mem_ready = 1'b0;
        settle();
        chk("drain_count", 64'(Count), 64'd0);
        chk("drain_empty", 64'(Empty), 64'd1);
        advance();

        // Directed table: forwarding, full stall, same-cycle release, drain order
        vecs.push_back(mk(1,  96,  5, 0,   0, 0, 0, 0,  0, 0,   0, 0));
        vecs.push_back(mk(1, 100,  6, 0,   0, 0, 0, 0,  0, 1,  96, 1));
        vecs.push_back(mk(1,  96,  9, 0,   0, 0, 0, 0,  0, 1,  96, 2));
        vecs.push_back(mk(0,   0,  0, 1,  96, 0, 0, 1,  9, 1,  96, 3));
        vecs.push_back(mk(0,   0,  0, 1,  98, 0, 0, 1,  9, 1,  96, 3));
        vecs.push_back(mk(0,   0,  0, 1, 200, 0, 0, 0,  0, 1,  96, 3));
        vecs.push_back(mk(0,   0,  0, 1, 100, 0, 0, 1,  6, 1,  96, 3));
        vecs.push_back(mk(1, 100, 12, 1, 100, 0, 0, 1,  6, 1,  96, 3));
        vecs.push_back(mk(1, 112, 13, 1, 100, 0, 1, 1, 12, 1,  96, 4));
        vecs.push_back(mk(1, 112, 13, 0,   0, 1, 0, 0,  0, 1,  96, 4));
        vecs.push_back(mk(0,   0,  0, 1,  96, 1, 0, 1,  9, 1, 100, 4));
        vecs.push_back(mk(0,   0,  0, 1,  96, 1, 0, 1,  9, 1,  96, 3));
        vecs.push_back(mk(0,   0,  0, 1,  96, 1, 0, 0,  0, 1, 100, 2));
        vecs.push_back(mk(0,   0,  0, 0,   0, 1, 0, 0,  0, 1, 112, 1));
        vecs.push_back(mk(0,   0,  0, 0,   0, 0, 0, 0,  0, 0,   0, 0));
        foreach (vecs[v]) begin
            drive(vecs[v].mw, vecs[v].adr, vecs[v].wd, vecs[v].lr, vecs[v].ladr, vecs[v].rdy);
            settle();
            chk($sformatf("v%0d_stall", v), 64'(StallStore), 64'(vecs[v].e_stall));
            chk($sformatf("v%0d_hit", v), 64'(LoadHit), 64'(vecs[v].e_hit));
            chk($sformatf("v%0d_ldata", v), 64'(LoadData), 64'(vecs[v].e_ld));
            chk($sformatf("v%0d_valid", v), 64'(mem_valid), 64'(vecs[v].e_valid));
            chk($sformatf("v%0d_count", v), 64'(Count), 64'(vecs[v].e_cnt));
            if (vecs[v].e_valid) chk($sformatf("v%0d_madr", v), 64'(mem_adr), 64'(vecs[v].e_madr));
            advance();
        end

        // Wrap-around: 20 back-to-back stores with mem_ready toggling every cycle
        record = 1'b1;
        i = 0;
        cyc = 0;
        while ((i < 20 || q.size() != 0) && cyc < 200) begin
            drive(i < 20, 32'(4 * i), 32'(i), 0, 0, cyc[0]);
            settle();
            chk("wrap_maxcnt", 64'(Count <= 3'd4), 64'd1);
            if (m_enq) i++;
            advance();
            cyc++;
        end
        record = 1'b0;
        chk("wrap_timeout", 64'(cyc < 200), 64'd1);
        chk("wrap_ndrained", 64'(drained.size()), 64'd20);
        foreach (drained[k]) begin
            chk("wrap_adr", 64'(drained[k].adr), 64'(4 * k));
            chk("wrap_data", 64'(drained[k].data), 64'(k));
        end

        // Asynchronous reset while draining three entries
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'(300 + 4 * k), 32'(50 + k), 0, 0, 0);
            settle();
            advance();
        end
        drive(0, 0, 0, 1, 300, 0);
        settle();
        chk("pre_rst_valid", 64'(mem_valid), 64'd1);
        reset = 1'b0;
        #1;
        chk("arst_valid", 64'(mem_valid), 64'd0);
        chk("arst_count", 64'(Count), 64'd0);
        chk("arst_empty", 64'(Empty), 64'd1);
        chk("arst_hit", 64'(LoadHit), 64'd0);
        advance();
        reset = 1'b1;
        mem_ready = 1'b1;
        repeat (3) begin
            settle();
            advance();
        end

        // Randomized traffic against the reference model; stalled stores are held
        m_stall = 1'b0;
        for (int r = 0; r < 400; r++) begin
            if (!m_stall) begin
                MemWrite  = 1'($urandom_range(0, 1));
                DataAdr   = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
                WriteData = $urandom;
            end
            LoadReq   = 1'($urandom_range(0, 1));
            LoadAdr   = {27'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            mem_ready = ($urandom_range(0, 2) == 0);
            settle();
            advance();
        end
        drive(0, 0, 0, 0, 0, 1);
        repeat (6) begin
            settle();
            advance();
        end
        chk("final_empty", 64'(Empty), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Posted-write FIFO between the core's data-store port (MemWrite / DataAdr / WriteData) and a slower data memory with a valid/ready write interface.
- Stores retire from the core in one cycle; the buffer drains them to memory in program order.
- Loads snoop the buffer, and the youngest matching pending store is forwarded.
- The core stalls only when the buffer is full.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, at least 2.
- AW, 32, address width.
- DW, 32, data width. Word stores only.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- MemWrite  in  1  core store request this cycle.
- DataAdr  in  AW  store byte address.
- WriteData  in  DW  store data.
- StallStore  out  1  store not accepted this cycle; core must hold the request.
- LoadReq  in  1  core load lookup this cycle.
- LoadAdr  in  AW  load byte address.
- LoadHit  out  1  a pending store matches LoadAdr.
- LoadData  out  DW  data of the youngest matching pending store.
- mem_valid  out  1  head entry presented to memory.
- mem_adr  out  AW  head entry address.
- mem_wdata  out  DW  head entry data.
- mem_ready  in  1  memory accepts the head entry this cycle.
- Empty  out  1  no pending stores.
- Count  out  $clog2(DEPTH+1)  number of pending stores.

Behaviour:
- Reset (reset==0, asynchronous):
  - Count=0, head/tail pointers=0, Empty=1, mem_valid=0, StallStore=0, LoadHit=0.
  - Entry storage is not reset; contents are don't-care.
  - A store in flight at reset assertion is dropped.
- Storage: circular array of DEPTH {adr, data} entries. Write at tail, read at head, pointers wrap modulo DEPTH.
- Dequeue, deq = mem_valid & mem_ready:
  - mem_valid = (Count != 0), combinational from state.
  - mem_adr and mem_wdata are driven from the head entry.
  - While mem_valid & !mem_ready, mem_adr and mem_wdata stay stable.
  - On deq, head advances at the next edge.
- Enqueue, enq = MemWrite & !StallStore:
  - StallStore = MemWrite & (Count==DEPTH) & !mem_ready.
  - When full, a same-cycle dequeue frees a slot, so the store is accepted. This makes a combinational path from mem_ready to StallStore; this path is intended.
  - On enq, DataAdr and WriteData are written at tail, and tail advances at the next edge.
- Count update: Count_next = Count + enq − deq. A simultaneous enq and deq leaves Count unchanged.
- Empty-to-memory latency: a store accepted at edge N is visible on mem_valid in cycle N+1. There is no same-cycle pass-through.
- No coalescing: repeated stores to one address occupy separate entries and drain separately, oldest first.
- Forwarding (combinational):
  - Compare address bits [AW-1:2] of LoadAdr against every occupied entry.
  - LoadHit = LoadReq & (any match).
  - LoadData = data of the match nearest the tail (youngest); 0 when LoadHit=0.
  - The head entry being dequeued this cycle still participates.
  - A store being enqueued in the same cycle does not participate; forwarding uses pre-edge contents only.
- Wrap-around: correct for any number of enqueue/dequeue cycles. Full vs empty is distinguished by Count, not by pointer equality alone.
- Protocol violation: MemWrite held while StallStore=1 is legal; the store is retried until accepted and is never duplicated.

Test Plan:
- Reset then idle:
  - Drive reset=0 for 2 cycles, then 1, no requests → Empty=1, Count=0, mem_valid=0, StallStore=0, LoadHit=0.
- Single store and drain:
  - Store adr=100, data=7 with mem_ready=0 → next cycle mem_valid=1, mem_adr=100, mem_wdata=7, held stable for 3 cycles.
  - Raise mem_ready → one cycle later Count=0, Empty=1.
- Fill and stall:
  - mem_ready=0, stores to 96, 100, 104, 108, then a 5th store to 112 → StallStore=1 on the 5th, Count=4.
  - Raise mem_ready in that cycle → StallStore=0, 112 accepted, Count stays 4.
  - Drain order observed on mem_adr: 96, 100, 104, 108, 112.
- Forwarding youngest:
  - Pending stores (96,5), (100,6), (96,9); LoadReq adr=96 → LoadHit=1, LoadData=9.
  - LoadAdr=98 → LoadHit=1, LoadData=9 (same word).
  - LoadAdr=200 → LoadHit=0, LoadData=0.
- Wrap-around with continuous traffic:
  - 20 back-to-back stores (adr=4*i, data=i), mem_ready toggling 1/0 each cycle → all 20 appear on the memory interface in order.
  - No data corruption, Count never exceeds 4.
- Async reset mid-drain:
  - With 3 entries pending and mem_valid=1, pull reset low between edges → mem_valid=0 and Count=0 immediately.
  - After release, no stale entry is presented.
